frame_builder_scheduler: RTL and testbench

- Arbitrates three response requesters (error, read, write) onto the single Frame_Builder instance.
- Latches the winner's operands and drives the builder's cmd/addr/data/error_status/start_frame.
- Tracks frame completion by counting the builder's tx_fifo_write pulses against the expected frame length.
- Sits between the register-access command handler and Frame_Builder in the UART response path; enforces one frame in flight, an inter-frame gap and a stall watchdog.

---
 rtl/frame_sched_pkg.sv | 11 +
 rtl/frame_req_arbiter.sv | 23 ++
 rtl/frame_builder_scheduler.sv | 106 ++++++++++
 tb/tb_frame_builder_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_sched_pkg.sv
// frame_sched_pkg: shared constants and types for the frame builder scheduler
package frame_sched_pkg;
  localparam logic [7:0] CMD_RD_RESP  = 8'hA1;
  localparam logic [7:0] CMD_WR_RESP  = 8'hA2;
  localparam logic [7:0] CMD_ERR_RESP = 8'hAE;
  localparam logic [3:0] LEN_RD  = 4'd12;
  localparam logic [3:0] LEN_WR  = 4'd8;
  localparam logic [3:0] LEN_ERR = 4'd4;
  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_GAP} state_t;
  typedef enum logic [1:0] {REQ_NONE, REQ_ERR, REQ_RD, REQ_WR} req_id_t;
endpackage

// File: rtl/frame_req_arbiter.sv
// frame_req_arbiter: error-first grant with read/write round-robin pointer
module frame_req_arbiter
  import frame_sched_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    en,
  input  logic    err_valid,
  input  logic    rd_valid,
  input  logic    wr_valid,
  output req_id_t gnt
);
  logic prefer_wr;
  always_comb
    gnt = !en ? REQ_NONE :
          err_valid ? REQ_ERR :
          (rd_valid && wr_valid) ? (prefer_wr ? REQ_WR : REQ_RD) :
          rd_valid ? REQ_RD :
          wr_valid ? REQ_WR : REQ_NONE;
  always_ff @(posedge clk)
    if (reset) prefer_wr <= 1'b0;
    else if (gnt == REQ_RD || gnt == REQ_WR) prefer_wr <= !prefer_wr;
endmodule

// File: rtl/frame_builder_scheduler.sv
// frame_builder_scheduler: arbitrates response requests onto one frame builder
module frame_builder_scheduler
  import frame_sched_pkg::*;
#(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             err_req_valid,
  output logic             err_req_ready,
  input  logic [7:0]       err_req_status,
  input  logic             rd_req_valid,
  output logic             rd_req_ready,
  input  logic [31:0]      rd_req_addr,
  input  logic [31:0]      rd_req_data,
  input  logic             wr_req_valid,
  output logic             wr_req_ready,
  input  logic [31:0]      wr_req_addr,
  output logic [7:0]       fb_cmd,
  output logic [31:0]      fb_addr,
  output logic [31:0]      fb_data,
  output logic [7:0]       fb_error_status,
  output logic             fb_start_frame,
  input  logic             fb_tx_fifo_write,
  input  logic             tx_fifo_full,
  output logic             busy,
  output logic             timeout_err,
  output logic             unexpected_write,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] timeout_count
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW   = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  state_t          state, post;
  req_id_t         gnt;
  logic [3:0]      byte_cnt, exp_len;
  logic [WD_W-1:0] wd_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            in_frame, done, expire;
  frame_req_arbiter u_arb (
    .clk(clk), .reset(reset), .en(state == ST_IDLE),
    .err_valid(err_req_valid), .rd_valid(rd_req_valid), .wr_valid(wr_req_valid),
    .gnt(gnt)
  );
  assign err_req_ready = gnt == REQ_ERR;
  assign rd_req_ready  = gnt == REQ_RD;
  assign wr_req_ready  = gnt == REQ_WR;
  assign busy     = state != ST_IDLE;
  assign post     = GAP_CYCLES == 0 ? ST_IDLE : ST_GAP;
  assign in_frame = state == ST_LAUNCH || state == ST_WAIT;
  assign done     = in_frame && fb_tx_fifo_write && byte_cnt + 4'd1 == exp_len;
  // a full FIFO holds the watchdog at zero, so backpressure can never abort a frame
  assign expire   = state == ST_WAIT && !fb_tx_fifo_write && !tx_fifo_full &&
                    wd_cnt == WD_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      fb_cmd <= '0;
      fb_addr <= '0;
      fb_data <= '0;
      fb_error_status <= '0;
      fb_start_frame <= 1'b0;
      timeout_err <= 1'b0;
      unexpected_write <= 1'b0;
      frame_count <= '0;
      timeout_count <= '0;
      byte_cnt <= '0;
      exp_len <= '0;
      wd_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      fb_start_frame <= 1'b0;
      timeout_err <= 1'b0;
      unexpected_write <= fb_tx_fifo_write && (state == ST_IDLE || state == ST_GAP);
      case (state)
        ST_IDLE: if (gnt != REQ_NONE) begin
          state <= ST_LAUNCH;
          fb_start_frame <= 1'b1;
          byte_cnt <= '0;
          wd_cnt <= '0;
          fb_cmd <= gnt == REQ_ERR ? CMD_ERR_RESP : gnt == REQ_RD ? CMD_RD_RESP : CMD_WR_RESP;
          fb_addr <= gnt == REQ_RD ? rd_req_addr : gnt == REQ_WR ? wr_req_addr : '0;
          fb_data <= gnt == REQ_RD ? rd_req_data : '0;
          fb_error_status <= gnt == REQ_ERR ? err_req_status : '0;
          exp_len <= gnt == REQ_ERR ? LEN_ERR : gnt == REQ_RD ? LEN_RD : LEN_WR;
        end
        ST_LAUNCH, ST_WAIT: begin
          state <= done || expire ? post : ST_WAIT;
          byte_cnt <= byte_cnt + 4'(fb_tx_fifo_write);
          wd_cnt <= fb_tx_fifo_write || tx_fifo_full || state == ST_LAUNCH ? '0 : wd_cnt + 1'b1;
          gap_cnt <= '0;
          if (done) frame_count <= frame_count + 1'b1;
          timeout_err <= !done && expire;
          if (!done && expire && !(&timeout_count)) timeout_count <= timeout_count + 1'b1;
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_builder_scheduler.sv
// tb_frame_builder_scheduler: randomized self-checking bench with a transaction-level model
module tb_frame_builder_scheduler;
  logic        clk = 1'b0;
  logic        reset;
  logic        err_req_valid, rd_req_valid, wr_req_valid;
  logic        err_req_ready, rd_req_ready, wr_req_ready;
  logic [7:0]  err_req_status;
  logic [31:0] rd_req_addr, rd_req_data, wr_req_addr;
  logic [7:0]  fb_cmd, fb_error_status;
  logic [31:0] fb_addr, fb_data;
  logic        fb_start_frame, fb_tx_fifo_write, tx_fifo_full;
  logic        busy, timeout_err, unexpected_write;
  logic [15:0] frame_count, timeout_count;
  logic [2:0]  rdy;
  int compared = 0, mismatched = 0;
  int m_frames = 0;
  bit m_pref_wr = 0;

  frame_builder_scheduler #(.GAP_CYCLES(2), .TIMEOUT_CYCLES(1024), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .err_req_valid(err_req_valid), .err_req_ready(err_req_ready), .err_req_status(err_req_status),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr), .rd_req_data(rd_req_data),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .fb_cmd(fb_cmd), .fb_addr(fb_addr), .fb_data(fb_data), .fb_error_status(fb_error_status),
    .fb_start_frame(fb_start_frame), .fb_tx_fifo_write(fb_tx_fifo_write), .tx_fifo_full(tx_fifo_full),
    .busy(busy), .timeout_err(timeout_err), .unexpected_write(unexpected_write),
    .frame_count(frame_count), .timeout_count(timeout_count)
  );

  assign rdy = {err_req_ready, rd_req_ready, wr_req_ready};
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(bit e, bit r, bit w);
    if (e) return 1;
    if (r && w) return m_pref_wr ? 3 : 2;
    if (r) return 2;
    if (w) return 3;
    return 0;
  endfunction

  task automatic do_reset();
    err_req_valid = 0; rd_req_valid = 0; wr_req_valid = 0;
    fb_tx_fifo_write = 0; tx_fifo_full = 0;
    reset = 1;
    step(); step();
    reset = 0;
    m_pref_wr = 0; m_frames = 0;
  endtask

  // grants whoever the model expects, plays the builder, then checks the gap
  task automatic serve(input bit keep, input bit stray, output logic [7:0] cmd_seen);
    int who, n, len;
    logic [7:0] ecmd, est;
    logic [31:0] ea, ed;
    logic [2:0] erdy;
    #1;
    who = pick(err_req_valid, rd_req_valid, wr_req_valid);
    erdy = who == 1 ? 3'b100 : who == 2 ? 3'b010 : who == 3 ? 3'b001 : 3'b000;
    compared++;
    if (rdy !== erdy) begin
      mismatched++;
      $display("FAIL grant_ready: got %b want %b", rdy, erdy);
    end
    cmd_seen = 8'h00;
    if (who == 0) return;
    ecmd = who == 1 ? 8'hAE : who == 2 ? 8'hA1 : 8'hA2;
    ea   = who == 2 ? rd_req_addr : who == 3 ? wr_req_addr : 32'h0;
    ed   = who == 2 ? rd_req_data : 32'h0;
    est  = who == 1 ? err_req_status : 8'h00;
    len  = who == 1 ? 4 : who == 2 ? 12 : 8;
    if (who != 1) m_pref_wr = !m_pref_wr;
    step();
    if (!keep) begin
      if (who == 1) err_req_valid = 0;
      else if (who == 2) rd_req_valid = 0;
      else wr_req_valid = 0;
    end
    #1;
    compared++;
    if ({fb_start_frame, busy, rdy, fb_cmd, fb_addr, fb_data, fb_error_status} !==
        {1'b1, 1'b1, 3'b000, ecmd, ea, ed, est}) begin
      mismatched++;
      $display("FAIL launch: got start=%b busy=%b rdy=%b cmd=%h addr=%h data=%h st=%h want cmd=%h addr=%h data=%h st=%h",
               fb_start_frame, busy, rdy, fb_cmd, fb_addr, fb_data, fb_error_status, ecmd, ea, ed, est);
    end
    cmd_seen = fb_cmd;
    n = 0;
    while (n < len) begin
      fb_tx_fifo_write = ($urandom_range(0, 2) != 0);
      step();
      if (fb_tx_fifo_write) n++;
      compared++;
      if ({fb_start_frame, rdy, timeout_err, unexpected_write, fb_cmd, fb_addr, fb_data, fb_error_status} !==
          {1'b0, 3'b000, 1'b0, 1'b0, ecmd, ea, ed, est}) begin
        mismatched++;
        $display("FAIL in_frame: got start=%b rdy=%b to=%b uw=%b cmd=%h want cmd=%h",
                 fb_start_frame, rdy, timeout_err, unexpected_write, fb_cmd, ecmd);
      end
      if (n < len) begin
        compared++;
        if (frame_count !== m_frames[15:0]) begin
          mismatched++;
          $display("FAIL early_complete: frame_count=%0d want %0d after %0d of %0d writes",
                   frame_count, m_frames, n, len);
        end
      end
    end
    fb_tx_fifo_write = 0;
    m_frames++;
    compared++;
    if ({busy, frame_count} !== {1'b1, m_frames[15:0]}) begin
      mismatched++;
      $display("FAIL complete: busy=%b frame_count=%0d want busy=1 count=%0d", busy, frame_count, m_frames);
    end
    fb_tx_fifo_write = stray;
    step();
    fb_tx_fifo_write = 0;
    compared++;
    if ({busy, rdy, unexpected_write, frame_count} !== {1'b1, 3'b000, stray, m_frames[15:0]}) begin
      mismatched++;
      $display("FAIL gap: busy=%b rdy=%b uw=%b count=%0d want busy=1 rdy=000 uw=%b count=%0d",
               busy, rdy, unexpected_write, frame_count, stray, m_frames);
    end
    step();
    compared++;
    if ({busy, unexpected_write} !== 2'b00) begin
      mismatched++;
      $display("FAIL back_to_idle: busy=%b uw=%b want 0 0", busy, unexpected_write);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    compared++;
    if ({busy, rdy, fb_start_frame, timeout_err, unexpected_write, fb_cmd, fb_addr, fb_data,
         fb_error_status, frame_count, timeout_count} !== '0) begin
      mismatched++;
      $display("FAIL reset_state: busy=%b rdy=%b start=%b cmd=%h addr=%h fc=%0d tc=%0d want all zero",
               busy, rdy, fb_start_frame, fb_cmd, fb_addr, frame_count, timeout_count);
    end
  endtask

  task automatic test_read();
    logic [7:0] c;
    do_reset();
    rd_req_addr = 32'h12345678; rd_req_data = 32'hDEADBEEF;
    rd_req_valid = 1;
    serve(0, 0, c);
    compared++;
    if (c !== 8'hA1) begin
      mismatched++;
      $display("FAIL read_cmd: got %h want a1", c);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] c;
    logic [7:0] want [3] = '{8'hAE, 8'hA1, 8'hA2};
    do_reset();
    err_req_status = 8'h01;
    rd_req_addr = $urandom; rd_req_data = $urandom; wr_req_addr = $urandom;
    err_req_valid = 1; rd_req_valid = 1; wr_req_valid = 1;
    for (int i = 0; i < 3; i++) begin
      serve(0, 0, c);
      compared++;
      if (c !== want[i]) begin
        mismatched++;
        $display("FAIL simultaneous_order: grant %0d cmd %h want %h", i, c, want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] c;
    do_reset();
    rd_req_addr = $urandom; rd_req_data = $urandom; wr_req_addr = $urandom;
    rd_req_valid = 1; wr_req_valid = 1;
    for (int i = 0; i < 4; i++) begin
      serve(1, 0, c);
      compared++;
      if (c !== ((i % 2) ? 8'hA2 : 8'hA1)) begin
        mismatched++;
        $display("FAIL alternate: frame %0d cmd %h want %h", i, c, (i % 2) ? 8'hA2 : 8'hA1);
      end
    end
    rd_req_valid = 0; wr_req_valid = 0;
  endtask

  task automatic test_full_stall();
    int to_seen = 0;
    do_reset();
    rd_req_addr = $urandom; rd_req_data = $urandom;
    rd_req_valid = 1;
    step();
    rd_req_valid = 0;
    fb_tx_fifo_write = 1;
    repeat (3) step();
    fb_tx_fifo_write = 0;
    tx_fifo_full = 1;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (timeout_err) to_seen++;
    end
    tx_fifo_full = 0;
    fb_tx_fifo_write = 1;
    repeat (9) step();
    fb_tx_fifo_write = 0;
    compared++;
    if (to_seen != 0 || {busy, frame_count, timeout_count} !== {1'b1, 16'd1, 16'd0}) begin
      mismatched++;
      $display("FAIL full_stall: timeouts=%0d busy=%b fc=%0d tc=%0d want 0 1 1 0",
               to_seen, busy, frame_count, timeout_count);
    end
    step(); step();
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL full_stall_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    bit seen = 0;
    logic [7:0] c;
    do_reset();
    rd_req_addr = $urandom; rd_req_data = $urandom;
    rd_req_valid = 1;
    step();
    rd_req_valid = 0;
    m_pref_wr = !m_pref_wr;
    fb_tx_fifo_write = 1;
    repeat (5) step();
    fb_tx_fifo_write = 0;
    while (n < 1100 && !seen) begin
      step();
      n++;
      if (timeout_err === 1'b1) seen = 1;
    end
    compared++;
    if (!seen || n != 1024) begin
      mismatched++;
      $display("FAIL timeout_latency: seen=%0d after %0d cycles want 1 after 1024", seen, n);
    end
    compared++;
    if ({timeout_count, frame_count, busy} !== {16'd1, 16'd0, 1'b1}) begin
      mismatched++;
      $display("FAIL timeout_counts: tc=%0d fc=%0d busy=%b want 1 0 1", timeout_count, frame_count, busy);
    end
    step();
    compared++;
    if (timeout_err !== 1'b0) begin
      mismatched++;
      $display("FAIL timeout_pulse: timeout_err=%b want 0", timeout_err);
    end
    step();
    wr_req_addr = $urandom;
    wr_req_valid = 1;
    serve(0, 0, c);
    compared++;
    if (c !== 8'hA2) begin
      mismatched++;
      $display("FAIL post_timeout_grant: cmd %h want a2", c);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] c;
    do_reset();
    err_req_status = $urandom;
    err_req_valid = 1;
    serve(0, 0, c);
    wr_req_addr = 32'hCAFEF00D;
    wr_req_valid = 1;
    step();
    wr_req_valid = 0;
    fb_tx_fifo_write = 1;
    step(); step();
    fb_tx_fifo_write = 0;
    reset = 1;
    step();
    reset = 0;
    m_pref_wr = 0; m_frames = 0;
    compared++;
    if ({busy, rdy, fb_start_frame, timeout_err, unexpected_write, fb_cmd, fb_addr, fb_data,
         fb_error_status, frame_count, timeout_count} !== '0) begin
      mismatched++;
      $display("FAIL reset_mid: busy=%b cmd=%h addr=%h fc=%0d tc=%0d want all zero",
               busy, fb_cmd, fb_addr, frame_count, timeout_count);
    end
    fb_tx_fifo_write = 1;
    step();
    fb_tx_fifo_write = 0;
    compared++;
    if ({unexpected_write, busy, frame_count} !== {1'b1, 1'b0, 16'd0}) begin
      mismatched++;
      $display("FAIL stray_idle: uw=%b busy=%b fc=%0d want 1 0 0", unexpected_write, busy, frame_count);
    end
    step();
    compared++;
    if (unexpected_write !== 1'b0) begin
      mismatched++;
      $display("FAIL stray_pulse: uw=%b want 0", unexpected_write);
    end
  endtask

  task automatic test_random();
    logic [7:0] c;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (!err_req_valid && $urandom_range(0, 3) == 0) begin
        err_req_status = $urandom; err_req_valid = 1;
      end
      if (!rd_req_valid && $urandom_range(0, 1) == 0) begin
        rd_req_addr = $urandom; rd_req_data = $urandom; rd_req_valid = 1;
      end
      if (!wr_req_valid && $urandom_range(0, 1) == 0) begin
        wr_req_addr = $urandom; wr_req_valid = 1;
      end
      if (!err_req_valid && !rd_req_valid && !wr_req_valid) begin
        rd_req_addr = $urandom; rd_req_data = $urandom; rd_req_valid = 1;
      end
      serve(0, $urandom_range(0, 1) == 1, c);
    end
    err_req_valid = 0; rd_req_valid = 0; wr_req_valid = 0;
  endtask

  initial begin
    err_req_status = 0; rd_req_addr = 0; rd_req_data = 0; wr_req_addr = 0;
    test_reset();
    test_read();
    test_simultaneous();
    test_back_to_back();
    test_full_stall();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
